// File: rtl/pc_ctrl.sv
// PC sequencing controller: picks advance / hold / redirect each cycle, parks a redirect raised during a stall.
// Zero latency (Mealy outputs load the PC at the same edge); stall holds the PC except for exceptions, which always issue.
module pc_ctrl #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  BOOT_CYCLES = 2,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR  = 32'h0000_0080
) (
    input  logic                pcc_clk,
    input  logic                pcc_rst,
    input  logic                pcc_i_stall,
    input  logic                pcc_i_exc,
    input  logic                pcc_i_eret,
    input  logic [PC_WIDTH-1:0] pcc_i_epc,
    input  logic                pcc_i_br_taken,
    input  logic [PC_WIDTH-1:0] pcc_i_br_target,
    input  logic                pcc_i_jmp,
    input  logic [PC_WIDTH-1:0] pcc_i_jmp_target,
    output logic                pcc_o_ce,
    output logic                pcc_o_change_pc,
    output logic [PC_WIDTH-1:0] pcc_o_pc,
    output logic                pcc_o_flush_if,
    output logic                pcc_o_flush_id,
    output logic [2:0]          pcc_o_src,
    output logic [15:0]         pcc_o_redirect_cnt
);

    typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_boot_cnt, w_boot_cnt_nxt;
    logic                  r_pend_vld, w_pend_vld_nxt;
    logic [PC_WIDTH-1:0]   r_pend_pc, w_pend_pc_nxt;
    logic [2:0]            r_pend_src, w_pend_src_nxt;
    logic [15:0]           r_cnt;

    logic [2:0]            w_live_src;
    logic [PC_WIDTH-1:0]   w_live_pc;
    logic                  w_live_wins;
    logic                  w_ce, w_chg;
    logic [PC_WIDTH-1:0]   w_pc;
    logic [2:0]            w_src;

    always_comb begin
        w_live_src = 3'b000;
        w_live_pc  = '0;
        if (pcc_i_exc) begin
            w_live_src = 3'b100;
            w_live_pc  = EXC_VECTOR;
        end else if (pcc_i_eret) begin
            w_live_src = 3'b100;
            w_live_pc  = pcc_i_epc;
        end else if (pcc_i_br_taken) begin
            w_live_src = 3'b010;
            w_live_pc  = pcc_i_br_target;
        end else if (pcc_i_jmp) begin
            w_live_src = 3'b001;
            w_live_pc  = pcc_i_jmp_target;
        end
    end

    // One-hot src orders numerically by priority; pend_src is zero whenever nothing is parked.
    assign w_live_wins = (w_live_src > r_pend_src);

    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_pc_nxt  = r_pend_pc;
        w_pend_src_nxt = r_pend_src;
        w_ce           = 1'b0;
        w_chg          = 1'b0;
        w_pc           = '0;
        w_src          = 3'b000;
        case (r_state)
            S_BOOT: begin
                w_boot_cnt_nxt = r_boot_cnt + 4'd1;
                if (r_boot_cnt == 4'(BOOT_CYCLES - 1))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (pcc_i_exc || !pcc_i_stall) begin
                    w_ce = 1'b1;
                    if (w_live_src != 3'b000) begin
                        w_chg = 1'b1;
                        w_pc  = w_live_pc;
                        w_src = w_live_src;
                    end
                end else begin
                    w_state_nxt    = S_HOLD;
                    w_pend_vld_nxt = |w_live_src;
                    w_pend_pc_nxt  = w_live_pc;
                    w_pend_src_nxt = w_live_src;
                end
            end
            S_HOLD: begin
                if (pcc_i_exc) begin
                    w_state_nxt    = S_RUN;
                    w_ce           = 1'b1;
                    w_chg          = 1'b1;
                    w_pc           = w_live_pc;
                    w_src          = w_live_src;
                    w_pend_vld_nxt = 1'b0;
                    w_pend_pc_nxt  = '0;
                    w_pend_src_nxt = 3'b000;
                end else if (pcc_i_stall) begin
                    if (w_live_wins) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_pc_nxt  = w_live_pc;
                        w_pend_src_nxt = w_live_src;
                    end
                end else begin
                    w_state_nxt    = S_RUN;
                    w_ce           = 1'b1;
                    w_pend_vld_nxt = 1'b0;
                    w_pend_pc_nxt  = '0;
                    w_pend_src_nxt = 3'b000;
                    if (w_live_wins) begin
                        w_chg = 1'b1;
                        w_pc  = w_live_pc;
                        w_src = w_live_src;
                    end else if (r_pend_vld) begin
                        w_chg = 1'b1;
                        w_pc  = r_pend_pc;
                        w_src = r_pend_src;
                    end
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge pcc_clk or posedge pcc_rst) begin
        if (pcc_rst) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= 4'd0;
            r_pend_vld <= 1'b0;
            r_pend_pc  <= '0;
            r_pend_src <= 3'b000;
            r_cnt      <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_pend_src <= w_pend_src_nxt;
            if (w_chg && (r_cnt != 16'hFFFF))
                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign pcc_o_ce           = w_ce;
    assign pcc_o_change_pc    = w_chg;
    assign pcc_o_pc           = w_pc;
    assign pcc_o_src          = w_src;
    assign pcc_o_flush_if     = |w_src;
    // Jumps resolve in ID, so only the IF slot is wrong-path for them.
    assign pcc_o_flush_id     = w_src[2] | w_src[1];
    assign pcc_o_redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: per-scenario stimulus tables, expected output words queued at drive time.
module tb_pc_ctrl;

    logic        pcc_clk, pcc_rst;
    logic        pcc_i_stall, pcc_i_exc, pcc_i_eret, pcc_i_br_taken, pcc_i_jmp;
    logic [31:0] pcc_i_epc, pcc_i_br_target, pcc_i_jmp_target;
    logic        pcc_o_ce, pcc_o_change_pc, pcc_o_flush_if, pcc_o_flush_id;
    logic [31:0] pcc_o_pc;
    logic [2:0]  pcc_o_src;
    logic [15:0] pcc_o_redirect_cnt;

    pc_ctrl #(.PC_WIDTH(32), .BOOT_CYCLES(2), .EXC_VECTOR(32'h0000_0080)) dut (
        .pcc_clk(pcc_clk), .pcc_rst(pcc_rst),
        .pcc_i_stall(pcc_i_stall), .pcc_i_exc(pcc_i_exc), .pcc_i_eret(pcc_i_eret),
        .pcc_i_epc(pcc_i_epc), .pcc_i_br_taken(pcc_i_br_taken), .pcc_i_br_target(pcc_i_br_target),
        .pcc_i_jmp(pcc_i_jmp), .pcc_i_jmp_target(pcc_i_jmp_target),
        .pcc_o_ce(pcc_o_ce), .pcc_o_change_pc(pcc_o_change_pc), .pcc_o_pc(pcc_o_pc),
        .pcc_o_flush_if(pcc_o_flush_if), .pcc_o_flush_id(pcc_o_flush_id),
        .pcc_o_src(pcc_o_src), .pcc_o_redirect_cnt(pcc_o_redirect_cnt)
    );

    initial pcc_clk = 1'b0;
    always #5 pcc_clk = ~pcc_clk;

    // Output word: {ce, change, pc, flush_if, flush_id, src, cnt}
    typedef struct packed {
        logic        stall, exc, eret;
        logic [31:0] epc;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic [54:0] e;
    } vec_t;

    logic [54:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [54:0] got, want;

    function automatic logic [54:0] mk(input logic ce, chg, input logic [31:0] pc,
                                       input logic fif, fid, input logic [2:0] src, input logic [15:0] cnt);
        return {ce, chg, pc, fif, fid, src, cnt};
    endfunction

    function automatic vec_t V(input logic stall, exc, eret, input logic [31:0] epc,
                               input logic br, input logic [31:0] brt, input logic jmp, input logic [31:0] jt,
                               input logic [54:0] e);
        vec_t v;
        v.stall = stall; v.exc = exc; v.eret = eret; v.epc = epc;
        v.br = br; v.brt = brt; v.jmp = jmp; v.jt = jt; v.e = e;
        return v;
    endfunction

    function automatic logic [54:0] obs();
        return {pcc_o_ce, pcc_o_change_pc, pcc_o_pc, pcc_o_flush_if, pcc_o_flush_id, pcc_o_src, pcc_o_redirect_cnt};
    endfunction

    task automatic apply(input vec_t v);
        pcc_i_stall = v.stall; pcc_i_exc = v.exc; pcc_i_eret = v.eret; pcc_i_epc = v.epc;
        pcc_i_br_taken = v.br; pcc_i_br_target = v.brt; pcc_i_jmp = v.jmp; pcc_i_jmp_target = v.jt;
    endtask

    task automatic test_reset();
        vec_t q[$];
        apply(V(0,0,0,0, 0,0, 0,0, '0));
        pcc_rst = 1'b1;
        #2;
        n_vec++;
        if (obs() !== 55'd0) begin n_err++; $display("FAIL reset_state got=%h want=%h", obs(), 55'd0); end
        @(posedge pcc_clk); #1;
        pcc_rst = 1'b0;
        q.push_back(V(0,0,0,0, 0,0, 1,32'h10, mk(0,0,0,0,0,3'b000,0)));
        q.push_back(V(0,0,0,0, 0,0, 1,32'h10, mk(0,0,0,0,0,3'b000,0)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,      mk(1,0,0,0,0,3'b000,0)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,      mk(1,0,0,0,0,3'b000,0)));
        foreach (q[i]) begin
            apply(q[i]); sb.push_back(q[i].e);
            @(negedge pcc_clk);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL boot[%0d] got=%h want=%h", i, got, want); end
            @(posedge pcc_clk); #1;
        end
    endtask

    task automatic test_priority();
        vec_t q[$];
        q.push_back(V(0,0,0,0, 1,32'h200, 1,32'h100, mk(1,1,32'h200,1,1,3'b010,0)));
        q.push_back(V(0,0,0,0, 0,0, 1,32'h44,        mk(1,1,32'h44,1,0,3'b001,1)));
        q.push_back(V(0,1,1,32'h999, 1,32'h200, 1,32'h100, mk(1,1,32'h80,1,1,3'b100,2)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,             mk(1,0,0,0,0,3'b000,3)));
        foreach (q[i]) begin
            apply(q[i]); sb.push_back(q[i].e);
            @(negedge pcc_clk);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL priority[%0d] got=%h want=%h", i, got, want); end
            @(posedge pcc_clk); #1;
        end
    endtask

    task automatic test_hold();
        vec_t q[$];
        q.push_back(V(1,0,0,0, 0,0, 1,32'h40,   mk(0,0,0,0,0,3'b000,3)));
        q.push_back(V(1,0,0,0, 1,32'h80, 0,0,   mk(0,0,0,0,0,3'b000,3)));
        q.push_back(V(1,0,0,0, 0,0, 1,32'h44,   mk(0,0,0,0,0,3'b000,3)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,        mk(1,1,32'h80,1,1,3'b010,3)));
        q.push_back(V(1,0,0,0, 0,0, 1,32'h48,   mk(0,0,0,0,0,3'b000,4)));
        q.push_back(V(0,0,0,0, 1,32'h500, 0,0,  mk(1,1,32'h500,1,1,3'b010,4)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,        mk(1,0,0,0,0,3'b000,5)));
        foreach (q[i]) begin
            apply(q[i]); sb.push_back(q[i].e);
            @(negedge pcc_clk);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL hold[%0d] got=%h want=%h", i, got, want); end
            @(posedge pcc_clk); #1;
        end
    endtask

    task automatic test_stall_exc();
        vec_t q[$];
        q.push_back(V(1,0,0,0, 1,32'h300, 0,0,  mk(0,0,0,0,0,3'b000,5)));
        q.push_back(V(1,1,0,0, 1,32'h300, 0,0,  mk(1,1,32'h80,1,1,3'b100,5)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,        mk(1,0,0,0,0,3'b000,6)));
        foreach (q[i]) begin
            apply(q[i]); sb.push_back(q[i].e);
            @(negedge pcc_clk);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL stall_exc[%0d] got=%h want=%h", i, got, want); end
            @(posedge pcc_clk); #1;
        end
    endtask

    task automatic test_eret();
        vec_t q[$];
        q.push_back(V(0,0,1,32'h1234, 0,0, 1,32'h10, mk(1,1,32'h1234,1,1,3'b100,6)));
        q.push_back(V(1,0,1,32'h2000, 0,0, 0,0,      mk(0,0,0,0,0,3'b000,7)));
        q.push_back(V(1,0,1,32'h3000, 0,0, 0,0,      mk(0,0,0,0,0,3'b000,7)));
        q.push_back(V(0,0,0,0, 0,0, 1,32'h20,        mk(1,1,32'h2000,1,1,3'b100,7)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,             mk(1,0,0,0,0,3'b000,8)));
        foreach (q[i]) begin
            apply(q[i]); sb.push_back(q[i].e);
            @(negedge pcc_clk);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL eret[%0d] got=%h want=%h", i, got, want); end
            @(posedge pcc_clk); #1;
        end
    endtask

    task automatic test_saturation();
        vec_t q[$];
        apply(V(0,0,0,0, 0,0, 1,32'h60, '0));
        for (int k = 0; k < 65535 - 8; k++) begin
            @(posedge pcc_clk); #1;
        end
        q.push_back(V(0,0,0,0, 0,0, 0,0,      mk(1,0,0,0,0,3'b000,16'hFFFF)));
        q.push_back(V(0,0,0,0, 0,0, 1,32'h60, mk(1,1,32'h60,1,0,3'b001,16'hFFFF)));
        q.push_back(V(0,0,0,0, 0,0, 0,0,      mk(1,0,0,0,0,3'b000,16'hFFFF)));
        foreach (q[i]) begin
            apply(q[i]); sb.push_back(q[i].e);
            @(negedge pcc_clk);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL saturation[%0d] got=%h want=%h", i, got, want); end
            @(posedge pcc_clk); #1;
        end
    endtask

    task automatic test_reset_mid_hold();
        vec_t q[$];
        apply(V(1,0,0,0, 0,0, 1,32'h40, '0));
        sb.push_back(mk(0,0,0,0,0,3'b000,16'hFFFF));
        @(negedge pcc_clk);
        got = obs(); want = sb.pop_front(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL midhold_park got=%h want=%h", got, want); end
        @(posedge pcc_clk); #1;
        apply(V(0,0,0,0, 0,0, 0,0, '0));
        pcc_rst = 1'b1;
        #1;
        n_vec++;
        if (obs() !== 55'd0) begin n_err++; $display("FAIL midhold_async_reset got=%h want=%h", obs(), 55'd0); end
        @(posedge pcc_clk); #1;
        pcc_rst = 1'b0;
        q.push_back(V(0,0,0,0, 0,0, 0,0, mk(0,0,0,0,0,3'b000,0)));
        q.push_back(V(0,0,0,0, 0,0, 0,0, mk(0,0,0,0,0,3'b000,0)));
        q.push_back(V(0,0,0,0, 0,0, 0,0, mk(1,0,0,0,0,3'b000,0)));
        q.push_back(V(0,0,0,0, 0,0, 0,0, mk(1,0,0,0,0,3'b000,0)));
        foreach (q[i]) begin
            apply(q[i]); sb.push_back(q[i].e);
            @(negedge pcc_clk);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL post_reset[%0d] got=%h want=%h", i, got, want); end
            @(posedge pcc_clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_hold();
        test_stall_exc();
        test_eret();
        test_saturation();
        test_reset_mid_hold();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
